// File: rtl/memory_load_store_unit_pkg.sv
// Shared types for the load/store unit and its byte-lane decoder.
package memory_load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  function automatic logic is_misaligned(input mem_access_t access, input logic [1:0] addr_lo);
    case (access)
      MEM_ACCESS_HALF: is_misaligned = addr_lo[0];
      MEM_ACCESS_WORD: is_misaligned = (addr_lo != 2'b00);
      default:         is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_column_decoder.sv
// Byte-lane enable decoder: maps access size and low address bits to column enables.
module memory_column_decoder
  import memory_load_store_unit_pkg::*;
#(
  parameter int L = 128,
  parameter int W = 32
) (
  input  logic [1:0]     i_addr_lo,
  input  mem_access_t    i_access,
  output logic [W/8-1:0] o_col_ena
);

  localparam int NB = W / 8;
  localparam int ADDR_W = $clog2(L);

  generate
    if (ADDR_W < 2) begin : g_bad_l
      $error("memory_column_decoder: L too small");
    end
  endgenerate

  always_comb begin
    o_col_ena = '0;
    case (i_access)
      MEM_ACCESS_BYTE: o_col_ena[i_addr_lo] = 1'b1;
      MEM_ACCESS_HALF: begin
        o_col_ena[{i_addr_lo[1], 1'b0}] = 1'b1;
        o_col_ena[{i_addr_lo[1], 1'b1}] = 1'b1;
      end
      MEM_ACCESS_WORD: o_col_ena = {NB{1'b1}};
      default:         o_col_ena = '0;
    endcase
  end

endmodule

// File: rtl/memory_load_store_unit.sv
// Single-outstanding load/store sequencer onto a byte-addressed data memory.
// Checks alignment/range at accept; replicates store data; extracts and extends load data.
module memory_load_store_unit
  import memory_load_store_unit_pkg::*;
#(
  parameter int L = 128,
  parameter int W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  mem_access_t           i_req_access,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic [$clog2(L)-1:0]  o_mem_addr,
  output logic                  o_mem_wr_ena,
  output logic [3:0]            o_mem_col_ena,
  output logic [31:0]           o_mem_wr_data,
  input  logic [31:0]           i_mem_rd_data,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_misaligned,
  output logic                  o_rsp_fault
);

  localparam int ADDR_W = $clog2(L);

  generate
    if (W != 32) begin : g_bad_w
      $error("memory_load_store_unit: only W=32 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READ, S_RESP} lsu_state_t;

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_write;
  mem_access_t       r_access;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_misaligned;
  logic              r_fault;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_fault;
  logic [3:0]        w_col_ena;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_load_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_accept     = (r_state == S_IDLE) && i_req_valid;
  assign w_misaligned = is_misaligned(i_req_access, i_req_addr[1:0]);
  assign w_fault      = (i_req_addr[31:ADDR_W] != '0);

  memory_column_decoder #(.L(L), .W(W)) u_col_dec (
    .i_addr_lo (r_addr[1:0]),
    .i_access  (r_access),
    .o_col_ena (w_col_ena)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req_valid) w_next = (w_misaligned || w_fault) ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = r_write ? S_RESP : S_READ;
      S_READ:   w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_data = r_wdata;
    case (r_access)
      MEM_ACCESS_BYTE: w_wr_data = {4{r_wdata[7:0]}};
      MEM_ACCESS_HALF: w_wr_data = {2{r_wdata[15:0]}};
      default:         w_wr_data = r_wdata;
    endcase
  end

  always_comb begin
    w_byte     = i_mem_rd_data[8*r_addr[1:0] +: 8];
    w_half     = r_addr[1] ? i_mem_rd_data[31:16] : i_mem_rd_data[15:0];
    w_load_ext = i_mem_rd_data;
    case (r_access)
      MEM_ACCESS_BYTE: w_load_ext = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      MEM_ACCESS_HALF: w_load_ext = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default:         w_load_ext = i_mem_rd_data;
    endcase
  end

  // Response fields are cleared at accept so stores and rejected requests report zero data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_access     <= MEM_ACCESS_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write      <= i_req_write;
        r_access     <= i_req_access;
        r_unsigned   <= i_req_unsigned;
        r_addr       <= i_req_addr[ADDR_W-1:0];
        r_wdata      <= i_req_wdata;
        r_rdata      <= '0;
        r_misaligned <= w_misaligned;
        r_fault      <= w_fault;
      end
      if (r_state == S_READ) r_rdata <= w_load_ext;
    end
  end

  assign o_req_ready      = (r_state == S_IDLE) && !i_rst;
  assign o_mem_addr       = r_addr;
  assign o_mem_wr_ena     = (r_state == S_ACCESS) && r_write;
  assign o_mem_col_ena    = (r_state == S_ACCESS) ? w_col_ena : 4'b0000;
  assign o_mem_wr_data    = w_wr_data;
  assign o_rsp_valid      = (r_state == S_RESP);
  assign o_rsp_rdata      = r_rdata;
  assign o_rsp_misaligned = r_misaligned;
  assign o_rsp_fault      = r_fault;

endmodule
